chinpo_mem_arbiter: RTL and testbench

Shares the single-ported CHINPO memory between two requesters:
- the CPU, whose control unit issues MemRead/MemWrite from its LW_Read/SW_Write states;
- a DMA/program-loader port.

The block sequences every access (issue, wait, capture, acknowledge) and produces a stall that holds the CPU control state machine in its memory state until the access completes.

---
 rtl/chinpo_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_chinpo_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chinpo_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : chinpo_mem_arbiter                                              |
// | Purpose  : Shares the single-ported CHINPO memory between the CPU and a    |
// |            DMA/program-loader port. Sequences each access through          |
// |            IDLE -> ACCESS -> (WAIT) -> (CAPTURE) -> DONE and stalls the    |
// |            CPU control unit until its access is acknowledged.              |
// | Options  : CHINPO_ARB_CPU_PRIORITY_EN - when defined, the CPU always wins  |
// |            ties (fixed priority); otherwise ties alternate round-robin.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module chinpo_mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              CLK,
   input  logic              Reset,
   // CPU port
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_ack,
   output logic              o_cpu_stall,
   // DMA / loader port
   input  logic              i_dma_req,
   input  logic              i_dma_we,
   input  logic [ADDR_W-1:0] i_dma_addr,
   input  logic [DATA_W-1:0] i_dma_wdata,
   output logic [DATA_W-1:0] o_dma_rdata,
   output logic              o_dma_ack,
   output logic              o_dma_stall,
   // Memory side
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_grant_dma
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ACCESS  = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [2:0] c_LAT     = 3'(MEM_LAT);
   localparam logic       c_OWN_CPU = 1'b0;
   localparam logic       c_OWN_DMA = 1'b1;

   // The wait counter is 3 bits wide, so the latency must fit in 1..7.
   if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
      $error("chinpo_mem_arbiter: MEM_LAT must be in 1..7");
   end

   state_t              r_state;
   logic                r_owner;
   logic [2:0]          r_cnt;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dma_rdata;
   logic                r_cpu_ack;
   logic                r_dma_ack;
   logic                r_grant_dma;
`ifndef CHINPO_ARB_CPU_PRIORITY_EN
   logic                r_last_owner;
`endif

   logic                w_any_req;
   logic                w_pick_dma;
   logic                w_win_we;
   logic [ADDR_W-1:0]   w_win_addr;
   logic [DATA_W-1:0]   w_win_wdata;

   // Winner selection: DMA wins when it is alone, or on a tie when the
   // tie-break rule favours it.
`ifdef CHINPO_ARB_CPU_PRIORITY_EN
   assign w_pick_dma  = i_dma_req & ~i_cpu_req;
`else
   assign w_pick_dma  = i_dma_req & (~i_cpu_req | (r_last_owner == c_OWN_CPU));
`endif
   assign w_any_req   = i_cpu_req | i_dma_req;
   assign w_win_we    = w_pick_dma ? i_dma_we    : i_cpu_we;
   assign w_win_addr  = w_pick_dma ? i_dma_addr  : i_cpu_addr;
   assign w_win_wdata = w_pick_dma ? i_dma_wdata : i_cpu_wdata;

   // Access sequencer: arbitrate in IDLE, strobe memory, count read latency,
   // capture read data into the owner's register and pulse the owner's ack.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_owner      <= c_OWN_CPU;
         r_cnt        <= 3'd0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_rdata  <= '0;
         r_dma_rdata  <= '0;
         r_cpu_ack    <= 1'b0;
         r_dma_ack    <= 1'b0;
         r_grant_dma  <= 1'b0;
`ifndef CHINPO_ARB_CPU_PRIORITY_EN
         r_last_owner <= c_OWN_DMA;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  // The memory-side registers double as the latched request.
                  r_owner     <= w_pick_dma;
                  r_grant_dma <= w_pick_dma;
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= w_win_we;
                  r_mem_addr  <= w_win_addr;
                  r_mem_wdata <= w_win_wdata;
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               if (r_mem_we) begin
                  r_cpu_ack <= (r_owner == c_OWN_CPU);
                  r_dma_ack <= (r_owner == c_OWN_DMA);
                  r_state   <= S_DONE;
               end else begin
                  // Data is valid MEM_LAT cycles after the strobe; with a
                  // latency of one the very next cycle is the capture cycle.
                  r_cnt   <= c_LAT;
                  r_state <= (c_LAT == 3'd1) ? S_CAPTURE : S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt <= 3'd2) begin
                  r_state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (r_owner == c_OWN_DMA) begin
                  r_dma_rdata <= i_mem_rdata;
               end else begin
                  r_cpu_rdata <= i_mem_rdata;
               end
               r_cpu_ack <= (r_owner == c_OWN_CPU);
               r_dma_ack <= (r_owner == c_OWN_DMA);
               r_state   <= S_DONE;
            end
            S_DONE: begin
               r_cpu_ack    <= 1'b0;
               r_dma_ack    <= 1'b0;
               r_grant_dma  <= 1'b0;
`ifndef CHINPO_ARB_CPU_PRIORITY_EN
               r_last_owner <= r_owner;
`endif
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_cpu_rdata = r_cpu_rdata;
   assign o_cpu_ack   = r_cpu_ack;
   assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;
   assign o_dma_rdata = r_dma_rdata;
   assign o_dma_ack   = r_dma_ack;
   assign o_dma_stall = i_dma_req & ~r_dma_ack;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_grant_dma = r_grant_dma;

endmodule
`default_nettype wire

// File: tb/tb_chinpo_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_chinpo_mem_arbiter                                           |
// | Purpose  : Directed self-checking bench for chinpo_mem_arbiter; instance A |
// |            uses MEM_LAT = 1, instance B uses MEM_LAT = 3.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_chinpo_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // ---------------- instance A (MEM_LAT = 1) ----------------
   logic        a_rst = 1'b1;
   logic        a_cpu_req = 0, a_cpu_we = 0, a_dma_req = 0, a_dma_we = 0;
   logic [15:0] a_cpu_addr = 0, a_cpu_wdata = 0, a_dma_addr = 0, a_dma_wdata = 0;
   logic [15:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        a_cpu_ack, a_cpu_stall, a_dma_ack, a_dma_stall, a_mem_en, a_mem_we, a_grant_dma;

   chinpo_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut_a (
      .CLK(clk), .Reset(a_rst),
      .i_cpu_req(a_cpu_req), .i_cpu_we(a_cpu_we), .i_cpu_addr(a_cpu_addr), .i_cpu_wdata(a_cpu_wdata),
      .o_cpu_rdata(a_cpu_rdata), .o_cpu_ack(a_cpu_ack), .o_cpu_stall(a_cpu_stall),
      .i_dma_req(a_dma_req), .i_dma_we(a_dma_we), .i_dma_addr(a_dma_addr), .i_dma_wdata(a_dma_wdata),
      .o_dma_rdata(a_dma_rdata), .o_dma_ack(a_dma_ack), .o_dma_stall(a_dma_stall),
      .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
      .i_mem_rdata(a_mem_rdata), .o_grant_dma(a_grant_dma)
   );

   // ---------------- instance B (MEM_LAT = 3) ----------------
   logic        b_rst = 1'b1;
   logic        b_cpu_req = 0, b_cpu_we = 0, b_dma_req = 0, b_dma_we = 0;
   logic [15:0] b_cpu_addr = 0, b_cpu_wdata = 0, b_dma_addr = 0, b_dma_wdata = 0;
   logic [15:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_dma_stall, b_mem_en, b_mem_we, b_grant_dma;

   chinpo_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut_b (
      .CLK(clk), .Reset(b_rst),
      .i_cpu_req(b_cpu_req), .i_cpu_we(b_cpu_we), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(b_cpu_wdata),
      .o_cpu_rdata(b_cpu_rdata), .o_cpu_ack(b_cpu_ack), .o_cpu_stall(b_cpu_stall),
      .i_dma_req(b_dma_req), .i_dma_we(b_dma_we), .i_dma_addr(b_dma_addr), .i_dma_wdata(b_dma_wdata),
      .o_dma_rdata(b_dma_rdata), .o_dma_ack(b_dma_ack), .o_dma_stall(b_dma_stall),
      .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
      .i_mem_rdata(b_mem_rdata), .o_grant_dma(b_grant_dma)
   );

   // Memory models: read data is presented only in the single cycle that is
   // exactly MEM_LAT cycles after the strobe; 0xDEAD at all other times.
   logic [15:0] a_mem [0:255];
   logic [15:0] a_rd_val = 16'h0;
   logic [2:0]  a_rd_cnt = 3'd0;
   always @(posedge clk) begin
      if (a_mem_en && a_mem_we) a_mem[a_mem_addr[7:0]] <= a_mem_wdata;
      if (a_mem_en && !a_mem_we) begin
         a_rd_val <= a_mem[a_mem_addr[7:0]];
         a_rd_cnt <= 3'd1;
      end else if (a_rd_cnt != 3'd0) begin
         a_rd_cnt <= a_rd_cnt - 3'd1;
      end
   end
   assign a_mem_rdata = (a_rd_cnt == 3'd1) ? a_rd_val : 16'hDEAD;

   logic [15:0] b_mem [0:255];
   logic [15:0] b_rd_val = 16'h0;
   logic [2:0]  b_rd_cnt = 3'd0;
   always @(posedge clk) begin
      if (b_mem_en && b_mem_we) b_mem[b_mem_addr[7:0]] <= b_mem_wdata;
      if (b_mem_en && !b_mem_we) begin
         b_rd_val <= b_mem[b_mem_addr[7:0]];
         b_rd_cnt <= 3'd3;
      end else if (b_rd_cnt != 3'd0) begin
         b_rd_cnt <= b_rd_cnt - 3'd1;
      end
   end
   assign b_mem_rdata = (b_rd_cnt == 3'd1) ? b_rd_val : 16'hDEAD;

   int b_dack_cnt = 0;
   always @(negedge clk) if (b_dma_ack) b_dack_cnt <= b_dack_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on instance A or B; called at cycle 0, returns in the cycle
   // after the ack with the request dropped. Checks the ack cycle.
   task automatic access(input bit inst_b, input bit dma, input bit we,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input int exp_cyc, input string tag);
      int got;
      logic ack;
      got = -1;
      if (!inst_b && !dma) begin a_cpu_req = 1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wd; end
      if (!inst_b &&  dma) begin a_dma_req = 1; a_dma_we = we; a_dma_addr = addr; a_dma_wdata = wd; end
      if ( inst_b && !dma) begin b_cpu_req = 1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wd; end
      if ( inst_b &&  dma) begin b_dma_req = 1; b_dma_we = we; b_dma_addr = addr; b_dma_wdata = wd; end
      for (int c = 0; c < 20 && got < 0; c++) begin
         @(negedge clk);
         ack = inst_b ? (dma ? b_dma_ack : b_cpu_ack) : (dma ? a_dma_ack : a_cpu_ack);
         if (ack) got = c;
         tick();
      end
      a_cpu_req = 0; a_dma_req = 0; b_cpu_req = 0; b_dma_req = 0;
      chk(tag, got, exp_cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ca0, ca1, da0, da1, cc, dc;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_ctl", {a_cpu_ack, a_dma_ack, a_mem_en, a_mem_we, a_grant_dma, a_cpu_stall, a_dma_stall}, 0);
      chk("rst_rdata", {a_cpu_rdata, a_dma_rdata}, 0);
      tick();
      a_rst = 0; b_rst = 0;
      tick();

      // Preload 0x0010 = 0xBEEF through the DMA port (write ack in cycle 2).
      access(0, 1, 1, 16'h0010, 16'hBEEF, 2, "pre_dma_wr_ack");

      // CPU read of 0x0010, MEM_LAT = 1.
      a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
      @(negedge clk); chk("t2_c0_stall", a_cpu_stall, 1); chk("t2_c0_en", a_mem_en, 0);
      tick(); @(negedge clk);
      chk("t2_c1_en_we", {a_mem_en, a_mem_we}, 2'b10); chk("t2_c1_addr", a_mem_addr, 16'h0010);
      chk("t2_c1_stall", a_cpu_stall, 1);
      tick(); @(negedge clk);
      chk("t2_c2_en_ack", {a_mem_en, a_cpu_ack}, 0); chk("t2_c2_stall", a_cpu_stall, 1);
      chk("t2_c2_addr_hold", a_mem_addr, 16'h0010);
      tick(); @(negedge clk);
      chk("t2_c3_ack", a_cpu_ack, 1); chk("t2_c3_rdata", a_cpu_rdata, 16'hBEEF);
      chk("t2_c3_stall", a_cpu_stall, 0);
      tick(); a_cpu_req = 0;
      @(negedge clk); chk("t2_c4_ack", a_cpu_ack, 0);
      tick();

      // DMA write of 0x1234 to 0x0020.
      a_dma_req = 1; a_dma_we = 1; a_dma_addr = 16'h0020; a_dma_wdata = 16'h1234;
      @(negedge clk); chk("t3_c0_grant", a_grant_dma, 0);
      tick(); @(negedge clk);
      chk("t3_c1_en_we", {a_mem_en, a_mem_we}, 2'b11); chk("t3_c1_wdata", a_mem_wdata, 16'h1234);
      chk("t3_c1_grant", a_grant_dma, 1); chk("t3_c1_ack", a_dma_ack, 0);
      tick(); @(negedge clk);
      chk("t3_c2_ack", a_dma_ack, 1); chk("t3_c2_grant", a_grant_dma, 1);
      chk("t3_c2_en", a_mem_en, 0);
      tick(); a_dma_req = 0;
      @(negedge clk); chk("t3_c3_grant", a_grant_dma, 0); chk("t3_cpu_rdata", a_cpu_rdata, 16'hBEEF);
      tick();

      // DMA readback leaves the CPU read register untouched.
      access(0, 1, 0, 16'h0020, 16'h0, 3, "rb_dma_rd_ack");
      chk("rb_dma_rdata", a_dma_rdata, 16'h1234);
      chk("rb_cpu_rdata", a_cpu_rdata, 16'hBEEF);

      // Reset asserted in the ACCESS cycle of a DMA write.
      a_dma_req = 1; a_dma_we = 1; a_dma_addr = 16'h0030; a_dma_wdata = 16'h5555;
      tick();
      a_rst = 1;
      @(negedge clk);
      chk("t1_ctl", {a_cpu_ack, a_dma_ack, a_mem_en, a_mem_we, a_grant_dma}, 0);
      chk("t1_rdata", {a_cpu_rdata, a_dma_rdata}, 0);
      chk("t1_addr_wdata", {a_mem_addr, a_mem_wdata}, 0);
      a_dma_req = 0;
      tick();
      a_rst = 0;
      @(negedge clk); chk("t1_idle", {a_mem_en, a_grant_dma, a_dma_ack}, 0);
      tick();

      // Simultaneous requests, both re-requesting immediately after each ack.
      a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h0040; a_cpu_wdata = 16'h1111;
      a_dma_req = 1; a_dma_we = 1; a_dma_addr = 16'h0041; a_dma_wdata = 16'h2222;
      ca0 = -1; ca1 = -1; da0 = -1; da1 = -1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (a_cpu_ack) begin if (ca0 < 0) ca0 = c; else if (ca1 < 0) ca1 = c; end
         if (a_dma_ack) begin if (da0 < 0) da0 = c; else if (da1 < 0) da1 = c; end
         tick();
         if (ca1 >= 0) a_cpu_req = 0;
         if (da1 >= 0) a_dma_req = 0;
      end
      a_cpu_req = 0; a_dma_req = 0;
`ifdef CHINPO_ARB_CPU_PRIORITY_EN
      chk("t4_cpu_ack0", ca0, 2); chk("t4_cpu_ack1", ca1, 5);
      chk("t4_dma_ack0", da0, 8); chk("t4_dma_ack1", da1, 11);
`else
      chk("t4_cpu_ack0", ca0, 2); chk("t4_dma_ack0", da0, 5);
      chk("t4_cpu_ack1", ca1, 8); chk("t4_dma_ack1", da1, 11);
`endif

      // Three simultaneous read pairs: CPU served first in each.
      for (int p = 0; p < 3; p++) begin
         a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
         a_dma_req = 1; a_dma_we = 0; a_dma_addr = 16'h0020;
         cc = -1; dc = -1;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_cpu_ack && cc < 0) cc = c;
            if (a_dma_ack && dc < 0) dc = c;
            tick();
            if (cc >= 0) a_cpu_req = 0;
            if (dc >= 0) a_dma_req = 0;
         end
         a_cpu_req = 0; a_dma_req = 0;
         chk($sformatf("t6_pair%0d_cpu_ack", p), cc, 3);
         chk($sformatf("t6_pair%0d_dma_ack", p), dc, 7);
      end
      chk("t6_cpu_rdata", a_cpu_rdata, 16'hBEEF);
      chk("t6_dma_rdata", a_dma_rdata, 16'h1234);

      // Instance B: MEM_LAT = 3, DMA read abandoned by Reset in second WAIT.
      access(1, 0, 1, 16'h0007, 16'h00A5, 2, "t5_cpu_wr_ack");
      b_dma_req = 1; b_dma_we = 0; b_dma_addr = 16'h0007;
      tick(); tick(); tick();
      b_rst = 1;
      @(negedge clk);
      chk("t5_rst_ctl", {b_dma_ack, b_grant_dma, b_mem_en}, 0);
      b_dma_req = 0;
      tick();
      b_rst = 0;
      @(negedge clk); chk("t5_idle", {b_grant_dma, b_mem_en, b_dma_ack}, 0);
      tick();
      access(1, 0, 0, 16'h0007, 16'h0, 5, "t5_cpu_rd_ack");
      chk("t5_cpu_rdata", b_cpu_rdata, 16'h00A5);
      chk("t5_dma_rdata", b_dma_rdata, 16'h0000);
      repeat (3) tick();
      chk("t5_no_dma_ack", b_dack_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
